decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port if_valid, input, 1 bit: fetch presents an instruction.
REQ-004 SHALL have port if_ready, output, 1 bit: decode accepts the instruction this cycle.
REQ-005 SHALL have ports if_instr (input, 32 bits: instruction word) and if_pc (input, 32 bits: its PC).
REQ-006 SHALL have port ex_ready, input, 1 bit: execute accepts the registered output this cycle.
REQ-007 SHALL have port flush, input, 1 bit: synchronous pipeline kill.
REQ-008 SHALL have port id_valid, output, 1 bit: registered outputs hold a real instruction.
REQ-009 SHALL have registered field outputs opcode[5:0], rd[3:0], rs[3:0], rt[3:0], cond[3:0], imm[17:0], md[21:0] and id_pc[31:0].
REQ-010 SHALL have registered 1-bit flag outputs is_alu_op, is_cmp_op, is_jmp_op, is_ld_op, is_str_op, is_call_op, is_ret_op and is_src2_imm.
REQ-011 SHALL have output illegal_seen, 1 bit: sticky flag set by any illegal opcode.

Function
REQ-012 SHALL slice fields from if_instr as follows: opcode=[31:26], rd=cond=[25:22], rs=[21:18], rt=[17:14], imm=[17:0], md=[21:0], all unextended.
REQ-013 SHALL decode opcode[5]=0 as ALU: is_alu_op=1 and is_src2_imm=opcode[0].
REQ-014 SHALL decode 0x20 as CMP register-register and 0x21 as CMP register-immediate (is_src2_imm=1).
REQ-015 SHALL decode 0x22 as JMP, 0x23 as LD (is_src2_imm=1), 0x24 as STR (is_src2_imm=1), 0x25 as CALL, 0x26 as RET and 0x27 as NOP (all flags 0).
REQ-016 SHALL treat opcodes 0x28-0x3F as illegal: all flags 0, id_valid still 1, and illegal_seen set on the cycle the instruction is loaded.
REQ-017 SHALL define the handshake as: transfer occurs when if_valid && if_ready; the output register loads on transfer.
REQ-018 SHALL hold all registered outputs unchanged while id_valid=1 && ex_ready=0 (stall), with if_ready=0.
REQ-019 SHALL set id_valid=0 on the next edge when no transfer occurs and ex_ready=1 (bubble).
REQ-020 SHALL detect a load-use hazard when id_valid && is_ld_op (registered) and the incoming instruction reads registered rd, where reads are defined as: rs for ALU/CMP/LD/STR; rt for ALU/CMP with opcode[0]=0; rd for STR.
REQ-021 SHALL, on a hazard, drive if_ready=0 and, if ex_ready=1, load a bubble (id_valid=0) for exactly one cycle; the held instruction transfers on the following cycle.
REQ-022 SHALL compute if_ready combinationally as !flush && (ex_ready || !id_valid) && !hazard.
REQ-023 SHALL, on flush=1, force id_valid=0 at the next edge, accept nothing, and take priority over stall and hazard.
REQ-024 SHALL compute hazard only against registered state, so back-to-back independent instructions sustain one per cycle.
REQ-025 SHALL clear illegal_seen only on reset.

Reset
REQ-026 SHALL, while rst_n=0, immediately drive id_valid, all fields, all flags, id_pc and illegal_seen to 0.
REQ-027 SHALL accept the first instruction on the first edge after rst_n rises.
REQ-028 SHALL discard any instruction in flight when reset asserts mid-stall, with no output after release until a new transfer.

Verification
REQ-029 SHALL verify: 0x08C48000 at pc 0x100 with ex_ready=1 -> next cycle id_valid=1, opcode=0x02, rd=3, rs=1, rt=2, is_alu_op=1, is_src2_imm=0, id_pc=0x100.
REQ-030 SHALL verify: LD 0x8D440004 followed by 0x08D48000 -> LD issues (rd=5, imm=4); next cycle if_ready=0 and id_valid=0 bubble; ADD issues one cycle later.
REQ-031 SHALL verify: 0x8BBFFFFF -> is_jmp_op=1, cond=0xE, md=0x3FFFFF; holding ex_ready=0 for 3 cycles keeps outputs stable and if_ready=0.
REQ-032 SHALL verify: flush asserted with if_valid=1 during stall -> id_valid=0 next cycle and the instruction is not accepted.
REQ-033 SHALL verify: opcode 0x30 -> id_valid=1 with all flags 0 and illegal_seen=1, which persists through subsequent legal instructions until rst_n=0.
REQ-034 SHALL verify: rst_n pulled low mid-stall -> all outputs 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/decode_stage.sv
// Instruction decode stage: slices fields, decodes class flags, and registers
// them behind a valid/ready handshake with load-use hazard and flush handling.
module decode_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        ex_ready,
  input  logic        flush,
  output logic        id_valid,
  output logic [5:0]  opcode,
  output logic [3:0]  rd,
  output logic [3:0]  rs,
  output logic [3:0]  rt,
  output logic [3:0]  cond,
  output logic [17:0] imm,
  output logic [21:0] md,
  output logic [31:0] id_pc,
  output logic        is_alu_op,
  output logic        is_cmp_op,
  output logic        is_jmp_op,
  output logic        is_ld_op,
  output logic        is_str_op,
  output logic        is_call_op,
  output logic        is_ret_op,
  output logic        is_src2_imm,
  output logic        illegal_seen
);

  logic [5:0]  w_op;
  logic [3:0]  w_rd, w_rs, w_rt;
  logic        w_alu, w_cmp, w_jmp, w_ld, w_str, w_call, w_ret, w_imm, w_illegal;
  logic        w_rd_rs, w_rd_rt, w_rd_rd;
  logic        w_hazard, w_xfer;

  logic        r_id_valid, r_illegal;
  logic [5:0]  r_opcode;
  logic [3:0]  r_rd, r_rs, r_rt;
  logic [17:0] r_imm;
  logic [21:0] r_md;
  logic [31:0] r_pc;
  logic [7:0]  r_flags;

  assign w_op = if_instr[31:26];
  assign w_rd = if_instr[25:22];
  assign w_rs = if_instr[21:18];
  assign w_rt = if_instr[17:14];

  always_comb begin
    w_alu = 1'b0; w_cmp = 1'b0; w_jmp = 1'b0; w_ld = 1'b0; w_str = 1'b0;
    w_call = 1'b0; w_ret = 1'b0; w_imm = 1'b0; w_illegal = 1'b0;
    w_rd_rs = 1'b0; w_rd_rt = 1'b0; w_rd_rd = 1'b0;
    if (!w_op[5]) begin
      w_alu = 1'b1; w_imm = w_op[0]; w_rd_rs = 1'b1; w_rd_rt = !w_op[0];
    end else begin
      case (w_op)
        6'h20: begin w_cmp = 1'b1; w_rd_rs = 1'b1; w_rd_rt = 1'b1; end
        6'h21: begin w_cmp = 1'b1; w_imm = 1'b1; w_rd_rs = 1'b1; end
        6'h22: w_jmp = 1'b1;
        6'h23: begin w_ld = 1'b1; w_imm = 1'b1; w_rd_rs = 1'b1; end
        6'h24: begin w_str = 1'b1; w_imm = 1'b1; w_rd_rs = 1'b1; w_rd_rd = 1'b1; end
        6'h25: w_call = 1'b1;
        6'h26: w_ret = 1'b1;
        6'h27: ;
        default: w_illegal = 1'b1;
      endcase
    end
  end

  // Hazard looks only at the registered LD so independent streams run at full rate.
  assign w_hazard = if_valid && r_id_valid && r_flags[4] &&
                    ((w_rd_rs && (w_rs == r_rd)) ||
                     (w_rd_rt && (w_rt == r_rd)) ||
                     (w_rd_rd && (w_rd == r_rd)));

  assign if_ready = !flush && (ex_ready || !r_id_valid) && !w_hazard;
  assign w_xfer   = if_valid && if_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid <= 1'b0;
      r_illegal  <= 1'b0;
      r_opcode   <= '0;
      r_rd       <= '0;
      r_rs       <= '0;
      r_rt       <= '0;
      r_imm      <= '0;
      r_md       <= '0;
      r_pc       <= '0;
      r_flags    <= '0;
    end else begin
      if (flush) begin
        r_id_valid <= 1'b0;
      end else if (w_xfer) begin
        r_id_valid <= 1'b1;
        r_opcode   <= w_op;
        r_rd       <= w_rd;
        r_rs       <= w_rs;
        r_rt       <= w_rt;
        r_imm      <= if_instr[17:0];
        r_md       <= if_instr[21:0];
        r_pc       <= if_pc;
        r_flags    <= {w_alu, w_cmp, w_jmp, w_ld, w_str, w_call, w_ret, w_imm};
      end else if (ex_ready) begin
        r_id_valid <= 1'b0;
      end
      if (w_xfer && w_illegal) r_illegal <= 1'b1;
    end
  end

  assign id_valid     = r_id_valid;
  assign opcode       = r_opcode;
  assign rd           = r_rd;
  assign cond         = r_rd;
  assign rs           = r_rs;
  assign rt           = r_rt;
  assign imm          = r_imm;
  assign md           = r_md;
  assign id_pc        = r_pc;
  assign {is_alu_op, is_cmp_op, is_jmp_op, is_ld_op,
          is_str_op, is_call_op, is_ret_op, is_src2_imm} = r_flags;
  assign illegal_seen = r_illegal;

endmodule
